// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receive front end.
// Conditions the raw PS/2 pins, deframes device-to-host frames (start, 8 data
// LSB first, odd parity, stop) and folds E0/F0 prefixes into ext/brk flags.
// Completed scan codes are queued in a small FIFO for the ASCII translator.
//
// Ports:
//   clk25, reset_in       system clock, asynchronous active-high reset
//   ps2_clk_i, ps2_data_i raw PS/2 pins (asynchronous)
//   read_kb               1-cycle pop strobe
//   kbd_code/ext/brk      FIFO head entry
//   kbd_available         FIFO not empty
//   frame_err             1-cycle pulse: bad start/parity/stop or mid-frame timeout
//   fifo_ovf              1-cycle pulse: entry dropped, FIFO full
//   err_count             saturating error count (only with KBD_RX_ERRCNT_EN)
//
// Optional feature macro: KBD_RX_ERRCNT_EN
module ps2_scancode_rx #(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk25,
  input  logic       reset_in,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       read_kb,
  output logic [7:0] kbd_code,
  output logic       kbd_ext,
  output logic       kbd_brk,
  output logic       kbd_available,
  output logic       frame_err,
  output logic       fifo_ovf
`ifdef KBD_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned FW    = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // Input conditioning
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  // Deframer
  state_t        r_state, w_state_nxt;
  logic [9:0]    r_shift, w_shift_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_ext_pend, w_ext_nxt;
  logic          r_brk_pend, w_brk_nxt;
  logic          w_push, w_ferr;
  logic [7:0]    w_byte;
  logic          w_frame_ok;
  logic [9:0]    w_push_data;

  // FIFO
  logic [9:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic               r_avail, r_frame_err, r_fifo_ovf;
  logic               w_empty, w_full, w_pop, w_wr, w_ovf;

  // Synchronize pins; filtered clock flips only after FILTER_LEN consecutive
  // synced samples that disagree with it. Reset to idle-high so no spurious fall.
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= ~r_clk_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_byte      = r_shift[7:0];
  assign w_frame_ok  = (^r_shift[8:0]) & r_shift[9];
  assign w_push_data = {r_ext_pend, r_brk_pend, w_byte};

  // Deframer state register
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_tmo      <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_ext_pend <= w_ext_nxt;
      r_brk_pend <= w_brk_nxt;
    end
  end

  // Deframer next state, timeout and prefix folding
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_tmo_nxt    = r_tmo;
    w_ext_nxt    = r_ext_pend;
    w_brk_nxt    = r_brk_pend;
    w_push       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmo_nxt = '0;
        // A fall with data high is line noise, not a start bit.
        if (r_fall && !r_dat_s2) begin
          w_state_nxt  = S_SHIFT;
          w_bitcnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (r_fall) begin
          w_shift_nxt  = {r_dat_s2, r_shift[9:1]};
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          w_tmo_nxt    = '0;
          if (r_bitcnt == 4'd9) w_state_nxt = S_CHECK;
        end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = '0;
          w_ferr      = 1'b1;
          w_ext_nxt   = 1'b0;
          w_brk_nxt   = 1'b0;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (!w_frame_ok) begin
          w_ferr    = 1'b1;
          w_ext_nxt = 1'b0;
          w_brk_nxt = 1'b0;
        end else if (w_byte == 8'hE0) begin
          w_ext_nxt = 1'b1;
        end else if (w_byte == 8'hF0) begin
          w_brk_nxt = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_ext_nxt = 1'b0;
          w_brk_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = read_kb & ~w_empty;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_ovf       = w_push & w_full & ~w_pop;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

  // FIFO storage, pointers and status pulses
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_avail     <= 1'b0;
      r_frame_err <= 1'b0;
      r_fifo_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count     <= w_count_nxt;
      r_avail     <= (w_count_nxt != '0);
      r_frame_err <= w_ferr;
      r_fifo_ovf  <= w_ovf;
    end
  end

  assign {kbd_ext, kbd_brk, kbd_code} = r_mem[r_rd_ptr];
  assign kbd_available = r_avail;
  assign frame_err     = r_frame_err;
  assign fifo_ovf      = r_fifo_ovf;

`ifdef KBD_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating error counter; frame errors and overflows never coincide.
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      r_err_cnt <= '0;
    end else if ((w_ferr | w_ovf) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed scenarios then random frames.
module tb_ps2_scancode_rx;

  localparam int HP    = 20;    // PS/2 half bit period in clk25 cycles
  localparam int TMO   = 2000;  // shortened timeout for simulation
  localparam int DEPTH = 8;

  logic       clk25 = 1'b0;
  logic       reset_in = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       read_kb = 1'b0;
  logic [7:0] kbd_code;
  logic       kbd_ext, kbd_brk, kbd_available, frame_err, fifo_ovf;
`ifdef KBD_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  ps2_scancode_rx #(
    .FIFO_AW    (3),
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk25        (clk25),
    .reset_in     (reset_in),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .read_kb      (read_kb),
    .kbd_code     (kbd_code),
    .kbd_ext      (kbd_ext),
    .kbd_brk      (kbd_brk),
    .kbd_available(kbd_available),
    .frame_err    (frame_err),
    .fifo_ovf     (fifo_ovf)
`ifdef KBD_RX_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk25 = ~clk25;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [9:0] exp_q[$];
  int  model_cnt = 0;
  bit  m_ext = 1'b0, m_brk = 1'b0;
  int  exp_ferr = 0, exp_ovf = 0, exp_err = 0;
  int  seen_ferr = 0, seen_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts status pulses, checks head entry whenever a pop is taken.
  always @(negedge clk25) begin
    logic [9:0] e;
    if (!reset_in) begin
      if (frame_err) seen_ferr++;
      if (fifo_ovf)  seen_ovf++;
      if (read_kb && kbd_available) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_head: got %h with no entry expected", {kbd_ext, kbd_brk, kbd_code});
        end else begin
          e = exp_q.pop_front();
          if ({kbd_ext, kbd_brk, kbd_code} !== e) begin
            failures++;
            $display("FAIL pop_head: got ext=%b brk=%b code=%h expected ext=%b brk=%b code=%h",
                     kbd_ext, kbd_brk, kbd_code, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk25);
      #2;
    end
  endtask

  task automatic err_inc();
    if (exp_err < 255) exp_err++;
  endtask

  // High-level rule set: prefixes accumulate, other bytes emit one entry.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_ferr++;
      err_inc();
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (model_cnt < DEPTH) begin
        exp_q.push_back({m_ext, m_brk, b});
        model_cnt++;
      end else begin
        exp_ovf++;
        err_inc();
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Drives nbits of a frame; lat = cycles from the last bit's clock fall to kbd_available.
  task automatic send_bits(input logic [10:0] bits, input int nbits, output int lat);
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = bits[i];
      tick(HP);
      ps2_clk_i = 1'b0;
      for (int j = 1; j <= HP; j++) begin
        tick(1);
        if (i == nbits - 1 && lat < 0 && kbd_available) lat = j;
      end
      ps2_clk_i = 1'b1;
    end
    tick(HP);
    ps2_data_i = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ferr_cnt"}, seen_ferr, exp_ferr);
    chk({tag, "_ovf_cnt"}, seen_ovf, exp_ovf);
    chk({tag, "_avail"}, int'(kbd_available), int'(model_cnt > 0));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            output int lat);
    logic [10:0] bits;
    logic        par;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    send_bits(bits, 11, lat);
    model_byte(b, !bad_par && !bad_stop);
  endtask

  task automatic good(input logic [7:0] b);
    int lat;
    send_frame(b, 1'b0, 1'b0, lat);
  endtask

  task automatic do_read();
    read_kb = 1'b1;
    tick(1);
    read_kb = 1'b0;
    if (model_cnt > 0) model_cnt--;
    tick(2);
  endtask

  task automatic do_reset();
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    reset_in   = 1'b1;
    tick(3);
    reset_in = 1'b0;
    tick(2);
    exp_q.delete();
    model_cnt = 0;
    m_ext     = 1'b0;
    m_brk     = 1'b0;
    exp_err   = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] b;
    logic [10:0] partial;

    // Reset state
    tick(3);
    chk("rst_code", int'(kbd_code), 0);
    chk("rst_ext", int'(kbd_ext), 0);
    chk("rst_brk", int'(kbd_brk), 0);
    chk("rst_avail", int'(kbd_available), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovf", int'(fifo_ovf), 0);
    reset_in = 1'b0;
    tick(5);

    // Single 0x1C frame and its latency from the pin edge (sync + filter + 2)
    send_frame(8'h1C, 1'b0, 1'b0, lat);
    chk("lat_in_window", int'(lat >= 10 && lat <= 14), 1);
    check_state("s1");
    do_read();
    check_state("s1_read");

    // E0 F0 75 folds into one entry; plain 75 afterwards
    good(8'hE0);
    good(8'hF0);
    check_state("s2_prefix");
    good(8'h75);
    check_state("s2_one");
    good(8'h75);
    do_read();
    do_read();
    check_state("s2_drained");

    // Bad parity after E0 clears the prefix
    good(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0, lat);
    check_state("s3_bad");
    good(8'h1C);
    do_read();
    check_state("s3_after");

    // Nine frames into an 8-entry FIFO
    for (int i = 1; i <= 9; i++) good(8'(i));
    check_state("s4_full");
    for (int i = 0; i < 8; i++) do_read();
    check_state("s4_drained");
    do_read();  // pop while empty must be ignored
    good(8'h33);
    do_read();
    check_state("s4_empty_pop");

    // Timeout after 5 bits
    partial = 11'h052;  // start=0 then a few data bits
    send_bits(partial, 5, lat);
    tick(TMO + 200);
    exp_ferr++;
    err_inc();
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_state("s5_tmo");
    good(8'h29);
    do_read();
    check_state("s5_after");

    // 4-cycle glitch with data low must not look like a start bit
    ps2_data_i = 1'b0;
    ps2_clk_i  = 1'b0;
    tick(4);
    ps2_clk_i = 1'b1;
    tick(2);
    ps2_data_i = 1'b1;
    tick(40);
    check_state("s6_glitch");
    good(8'h5A);
    do_read();
    check_state("s6_after");
`ifdef KBD_RX_ERRCNT_EN
    chk("err_count", int'(err_count), exp_err);
`endif

    // Reset mid-prefix and mid-frame
    good(8'hE0);
    partial = 11'h000;
    send_bits(partial, 4, lat);
    do_reset();
    chk("midrst_avail", int'(kbd_available), 0);
    good(8'h1C);
    do_read();
    check_state("s7_after");

    // Random frames with occasional errors and random reads
    for (int n = 0; n < 30; n++) begin
      int sel;
      bit bp, bs;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else               b = 8'($urandom_range(0, 255));
      bp = 1'b0;
      bs = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) bp = 1'b1;
        else                           bs = 1'b1;
      end
      send_frame(b, bp, bs, lat);
      check_state("rnd");
      for (int k = 0; k < int'($urandom_range(0, 1)); k++) do_read();
    end
    while (model_cnt > 0) do_read();
    check_state("final");
    chk("final_queue_empty", exp_q.size(), 0);
`ifdef KBD_RX_ERRCNT_EN
    chk("final_err_count", int'(err_count), exp_err);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
